// File: rtl/pfb_deadlock_watchdog_if.sv
// Flag and status bundle between the decimator kernel's stall probes and the deadlock watchdog.
// The watchdog takes the slave view; whoever drives the probes and reads the snapshot takes the master view.
interface pfb_deadlock_watchdog_if #(
  parameter int N_AXIS = 12,
  parameter int N_INST = 3,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = $clog2(N_AXIS + N_INST);

  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_INST-1:0] inst_idle_sigs;
  logic [N_INST-1:0] inst_block_sigs;
  logic              clear;
  logic              block;
  logic              suspect;
  logic [CNT_W-1:0]  stall_cycles;
  logic [N_AXIS-1:0] cause_axis;
  logic [N_INST-1:0] cause_inst;
  logic [IDX_W-1:0]  cause_idx;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    input  block, suspect, stall_cycles, cause_axis, cause_inst, cause_idx
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    output block, suspect, stall_cycles, cause_axis, cause_inst, cause_idx
  );
endinterface

// File: rtl/pfb_deadlock_watchdog.sv
// Stall watchdog for the pfb_multichannel_decimator dataflow kernel: raises a sticky deadlock
// after THRESH cycles of an unchanging stall pattern and freezes the offending flags for readback.
module pfb_deadlock_watchdog #(
  parameter int N_AXIS = 12,
  parameter int N_INST = 3,
  parameter int THRESH = 1024,
  parameter int CNT_W  = 16
) (
  input logic                    clock,
  input logic                    reset,
  pfb_deadlock_watchdog_if.slave bus
);
  localparam int PAT_W = N_AXIS + N_INST;
  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_DEADLOCK = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W-1:0]  w_count_inc;
  logic [PAT_W-1:0]  r_pat_q;
  logic [PAT_W-1:0]  w_pat_nxt;
  logic [PAT_W-1:0]  w_pattern;
  logic [N_AXIS-1:0] r_cause_axis;
  logic [N_AXIS-1:0] w_cause_axis_nxt;
  logic [N_INST-1:0] r_cause_inst;
  logic [N_INST-1:0] w_cause_inst_nxt;
  logic              r_block;
  logic              r_suspect;
  logic              w_stalled;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [PAT_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = PAT_W - 1; i >= 0; i--) begin
      idx = v[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  assign w_stalled   = (&(bus.inst_idle_sigs | bus.inst_block_sigs)) &
                       ((|bus.inst_block_sigs) | (|bus.axis_block_sigs));
  assign w_pattern   = {bus.inst_block_sigs, bus.axis_block_sigs};
  assign w_count_inc = r_count + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state, stall counter, pattern tracking and snapshot capture.
  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_pat_nxt        = r_pat_q;
    w_cause_axis_nxt = r_cause_axis;
    w_cause_inst_nxt = r_cause_inst;
    if (bus.clear) begin
      w_state_nxt      = ST_RUN;
      w_count_nxt      = '0;
      w_pat_nxt        = '0;
      w_cause_axis_nxt = '0;
      w_cause_inst_nxt = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_stalled) begin
            w_state_nxt = ST_SUSPECT;
            w_count_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
            w_pat_nxt   = w_pattern;
          end else begin
            w_count_nxt = '0;
          end
        end
        ST_SUSPECT: begin
          if (!w_stalled) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = '0;
          end else if (w_pattern != r_pat_q) begin
            // A shifting stall pattern means the kernel is still moving: restart the window.
            w_count_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
            w_pat_nxt   = w_pattern;
          end else begin
            w_count_nxt = w_count_inc;
            if (w_count_inc == THRESH_C) begin
              w_state_nxt      = ST_DEADLOCK;
              w_cause_axis_nxt = bus.axis_block_sigs;
              w_cause_inst_nxt = bus.inst_block_sigs;
            end else begin
              w_state_nxt = ST_SUSPECT;
            end
          end
        end
        ST_DEADLOCK: begin
          w_count_nxt = THRESH_C;
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // State, counter, snapshot and status flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_count      <= '0;
      r_pat_q      <= '0;
      r_cause_axis <= '0;
      r_cause_inst <= '0;
      r_block      <= 1'b0;
      r_suspect    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_pat_q      <= w_pat_nxt;
      r_cause_axis <= w_cause_axis_nxt;
      r_cause_inst <= w_cause_inst_nxt;
      r_block      <= (w_state_nxt == ST_DEADLOCK);
      r_suspect    <= (w_state_nxt == ST_SUSPECT);
    end
  end

  assign bus.block        = r_block;
  assign bus.suspect      = r_suspect;
  assign bus.stall_cycles = r_count;
  assign bus.cause_axis   = r_cause_axis;
  assign bus.cause_inst   = r_cause_inst;
  assign bus.cause_idx    = r_block ? lowest_set({r_cause_inst, r_cause_axis}) : {IDX_W{1'b0}};
endmodule

// File: tb/tb_pfb_deadlock_watchdog.sv
// Directed bench for pfb_deadlock_watchdog with THRESH=16; inputs change and outputs are
// sampled on the falling clock edge, away from the rising edge the DUT acts on.
module tb_pfb_deadlock_watchdog;
  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  pfb_deadlock_watchdog_if #(.N_AXIS(12), .N_INST(3), .CNT_W(16)) bus ();

  pfb_deadlock_watchdog #(.N_AXIS(12), .N_INST(3), .THRESH(16), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_in(input logic [11:0] axis, input logic [2:0] idle, input logic [2:0] blk);
    bus.axis_block_sigs = axis;
    bus.inst_idle_sigs  = idle;
    bus.inst_block_sigs = blk;
  endtask

  task automatic go_idle;
    set_in(12'h000, 3'b111, 3'b000);
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    bus.clear = 1'b0;
    set_in(12'h000, 3'b111, 3'b000);
    repeat (3) @(negedge clock);
    tests_run++;
    if (bus.block !== 1'b0 || bus.suspect !== 1'b0 || bus.stall_cycles !== 16'd0 ||
        bus.cause_axis !== 12'h000 || bus.cause_inst !== 3'b000 || bus.cause_idx !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_values: block=%b suspect=%b stall=%0d axis=%h inst=%b idx=%0d, expected all 0",
               bus.block, bus.suspect, bus.stall_cycles, bus.cause_axis, bus.cause_inst, bus.cause_idx);
    end
    reset = 1'b1;
  endtask

  task automatic test_idle;
    set_in(12'h000, 3'b111, 3'b000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      tests_run++;
      if (bus.block !== 1'b0 || bus.suspect !== 1'b0 || bus.stall_cycles !== 16'd0) begin
        tests_failed++;
        $display("FAIL idle_kernel cycle %0d: block=%b suspect=%b stall=%0d, expected 0/0/0",
                 i, bus.block, bus.suspect, bus.stall_cycles);
      end
    end
  endtask

  task automatic test_deadlock;
    set_in(12'h100, 3'b101, 3'b010);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      tests_run++;
      if (bus.stall_cycles !== 16'(i) || bus.suspect !== (i < 16) || bus.block !== (i == 16)) begin
        tests_failed++;
        $display("FAIL deadlock_window cycle %0d: stall=%0d suspect=%b block=%b, expected %0d/%b/%b",
                 i, bus.stall_cycles, bus.suspect, bus.block, i, (i < 16), (i == 16));
      end
    end
    tests_run++;
    if (bus.cause_axis !== 12'h100 || bus.cause_inst !== 3'b010 || bus.cause_idx !== 4'd8) begin
      tests_failed++;
      $display("FAIL deadlock_cause: axis=%h inst=%b idx=%0d, expected 100/010/8",
               bus.cause_axis, bus.cause_inst, bus.cause_idx);
    end
  endtask

  task automatic test_sticky_clear;
    set_in(12'h000, 3'b111, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      tests_run++;
      if (bus.block !== 1'b1 || bus.suspect !== 1'b0 || bus.stall_cycles !== 16'd16 ||
          bus.cause_axis !== 12'h100 || bus.cause_inst !== 3'b010 || bus.cause_idx !== 4'd8) begin
        tests_failed++;
        $display("FAIL sticky_hold cycle %0d: block=%b suspect=%b stall=%0d axis=%h inst=%b idx=%0d, expected 1/0/16/100/010/8",
                 i, bus.block, bus.suspect, bus.stall_cycles, bus.cause_axis, bus.cause_inst, bus.cause_idx);
      end
    end
    // Stall inputs present during the clear cycle must not start a new window in that cycle.
    set_in(12'h100, 3'b101, 3'b010);
    bus.clear = 1'b1;
    @(negedge clock);
    tests_run++;
    if (bus.block !== 1'b0 || bus.suspect !== 1'b0 || bus.stall_cycles !== 16'd0 ||
        bus.cause_axis !== 12'h000 || bus.cause_inst !== 3'b000 || bus.cause_idx !== 4'd0) begin
      tests_failed++;
      $display("FAIL clear_cycle: block=%b suspect=%b stall=%0d axis=%h inst=%b idx=%0d, expected all 0",
               bus.block, bus.suspect, bus.stall_cycles, bus.cause_axis, bus.cause_inst, bus.cause_idx);
    end
    bus.clear = 1'b0;
    @(negedge clock);
    tests_run++;
    if (bus.suspect !== 1'b1 || bus.stall_cycles !== 16'd1 || bus.block !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_clear_entry: suspect=%b stall=%0d block=%b, expected 1/1/0",
               bus.suspect, bus.stall_cycles, bus.block);
    end
    go_idle();
  endtask

  task automatic test_glitch;
    int peak;
    peak = 0;
    for (int i = 0; i < 21; i++) begin
      if (i == 10) set_in(12'h000, 3'b111, 3'b000);
      else         set_in(12'h100, 3'b101, 3'b010);
      @(negedge clock);
      if (int'(bus.stall_cycles) > peak) peak = int'(bus.stall_cycles);
      tests_run++;
      if (bus.stall_cycles !== 16'((i < 10) ? i + 1 : (i == 10) ? 0 : i - 10) || bus.block !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch cycle %0d: stall=%0d block=%b, expected %0d/0",
                 i, bus.stall_cycles, bus.block, (i < 10) ? i + 1 : (i == 10) ? 0 : i - 10);
      end
    end
    tests_run++;
    if (peak != 10) begin
      tests_failed++;
      $display("FAIL glitch_peak: peak=%0d, expected 10", peak);
    end
    go_idle();
  endtask

  task automatic test_pattern_change;
    for (int i = 0; i < 32; i++) begin
      set_in(((i / 8) % 2 == 0) ? 12'h001 : 12'h002, 3'b101, 3'b010);
      @(negedge clock);
      tests_run++;
      if (bus.stall_cycles !== 16'((i % 8) + 1) || bus.block !== 1'b0 || bus.suspect !== 1'b1) begin
        tests_failed++;
        $display("FAIL pattern_change cycle %0d: stall=%0d block=%b suspect=%b, expected %0d/0/1",
                 i, bus.stall_cycles, bus.block, bus.suspect, (i % 8) + 1);
      end
    end
    go_idle();
  endtask

  task automatic test_inst_cause;
    set_in(12'h000, 3'b011, 3'b100);
    repeat (16) @(negedge clock);
    tests_run++;
    if (bus.block !== 1'b1 || bus.cause_axis !== 12'h000 || bus.cause_inst !== 3'b100 || bus.cause_idx !== 4'd14) begin
      tests_failed++;
      $display("FAIL inst_cause: block=%b axis=%h inst=%b idx=%0d, expected 1/000/100/14",
               bus.block, bus.cause_axis, bus.cause_inst, bus.cause_idx);
    end
    set_in(12'h000, 3'b111, 3'b000);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    tests_run++;
    if (bus.block !== 1'b0 || bus.cause_idx !== 4'd0 || bus.cause_inst !== 3'b000) begin
      tests_failed++;
      $display("FAIL inst_cause_clear: block=%b idx=%0d inst=%b, expected 0/0/000",
               bus.block, bus.cause_idx, bus.cause_inst);
    end
  endtask

  task automatic test_async_reset;
    set_in(12'h100, 3'b101, 3'b010);
    repeat (12) @(negedge clock);
    tests_run++;
    if (bus.stall_cycles !== 16'd12 || bus.suspect !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_count: stall=%0d suspect=%b, expected 12/1", bus.stall_cycles, bus.suspect);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (bus.block !== 1'b0 || bus.suspect !== 1'b0 || bus.stall_cycles !== 16'd0 ||
        bus.cause_axis !== 12'h000 || bus.cause_inst !== 3'b000 || bus.cause_idx !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_reset: block=%b suspect=%b stall=%0d axis=%h inst=%b idx=%0d, expected all 0",
               bus.block, bus.suspect, bus.stall_cycles, bus.cause_axis, bus.cause_inst, bus.cause_idx);
    end
    @(negedge clock);
    set_in(12'h000, 3'b111, 3'b000);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_idle();
    test_deadlock();
    test_sticky_clear();
    test_glitch();
    test_pattern_change();
    test_inst_cause();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pfb_deadlock_watchdog.md
# pfb_deadlock_watchdog

Synthesizable stall watchdog for the `pfb_multichannel_decimator` kernel. It consumes the same per-channel AXI-Stream block flags and per-instance idle/block flags that the simulation deadlock monitor uses. It declares a deadlock when every dataflow instance (`read_inputs`, `compute_pfb`, `write_outputs`) has been idle-or-blocked, with at least one blocked, for `THRESH` consecutive cycles. On that event it latches the offending signal pattern for on-chip readback.

## Interface
Parameters:
- `N_AXIS`, 12, number of AXI-Stream block flags (8 input I/Q channels, 4 output channels).
- `N_INST`, 3, number of dataflow instances.
- `THRESH`, 1024, consecutive stalled cycles that constitute a deadlock; legal range 2..2^CNT_W−1.
- `CNT_W`, 16, stall counter width.

Ports:
- `clock`, in, 1, sole clock, rising edge.
- `reset`, in, 1, asynchronous, active-low reset.
- `axis_block_sigs`, in, N_AXIS, 1 = stream port blocked (inverted `TDATA_blk_n`).
- `inst_idle_sigs`, in, N_INST, 1 = instance `ap_idle`.
- `inst_block_sigs`, in, N_INST, 1 = instance blocked on FIFO or `ap_continue`.
- `clear`, in, 1, synchronous clear of the sticky deadlock and snapshot.
- `block`, out, 1, sticky deadlock flag.
- `suspect`, out, 1, stall in progress, below threshold.
- `stall_cycles`, out, CNT_W, current consecutive-stall count.
- `cause_axis`, out, N_AXIS, snapshot of `axis_block_sigs` at deadlock.
- `cause_inst`, out, N_INST, snapshot of `inst_block_sigs` at deadlock.
- `cause_idx`, out, $clog2(N_AXIS+N_INST), lowest set bit of {`cause_inst`, `cause_axis`}, with axis bits at indices 0..N_AXIS−1.

## Operation
- Combinational `stalled` = (&(`inst_idle_sigs` | `inst_block_sigs`)) & (|`inst_block_sigs` | |`axis_block_sigs`).
- Combinational `pattern` = {`inst_block_sigs`, `axis_block_sigs`}. A registered copy `pat_q` is held while in SUSPECT.
- States are RUN, SUSPECT and DEADLOCK, encoded as 2-bit values 0, 1 and 2.
- RUN:
  - Count = 0.
  - If `stalled`: go to SUSPECT, count = 1, `pat_q` = `pattern`.
- SUSPECT:
  - If !`stalled`: go to RUN, count = 0.
  - If `stalled` and `pattern` != `pat_q`, the kernel is treated as making progress: count = 1 and `pat_q` = `pattern`.
  - If `stalled` and `pattern` == `pat_q`: count += 1. When the incremented value equals `THRESH`, go to DEADLOCK and capture `cause_axis`/`cause_inst` from the current inputs.
- DEADLOCK:
  - Sticky. Count saturates at `THRESH`.
  - Inputs are ignored and the snapshot is frozen.
  - Leaves only on `clear` or reset.
- `clear` has priority over all transitions and returns the block to RUN from any state. The RUN-entry test is applied on the following cycle, never in the clear cycle.
- `cause_idx` is computed with a priority encoder from the snapshot registers, so it is valid whenever `block` = 1. It is 0 otherwise.
- Illegal state value: go to RUN.

## Timing
- Reset values: `block` = 0, `suspect` = 0, `stall_cycles` = 0, `cause_axis` = 0, `cause_inst` = 0, `cause_idx` = 0, state = RUN, `pat_q` = 0.
- All outputs are registered, except `cause_idx`, which is a combinational decode of registered snapshots.
- Detection latency: with `stalled` held constant from the sample at edge k through edge k+THRESH−1, `block` rises after edge k+THRESH−1. It is visible in the cycle following that edge.
- `suspect` is high exactly while in SUSPECT. `suspect` and `block` are never both 1.
- Pattern change behaves as follows: the cycle in which the pattern changes counts as stall cycle 1 of a new window.
- Single non-stalled cycle: count returns to 0, with no hysteresis.
- Reset asserted mid-SUSPECT or mid-DEADLOCK: outputs clear immediately (asynchronously). Deassertion is synchronized externally.
- `stall_cycles` never wraps, because `THRESH` ≤ 2^CNT_W−1.

## Test plan
- Reset, then idle kernel (`inst_idle_sigs`=3'b111, all block flags 0) for 100 cycles -> `block`=0, `suspect`=0, `stall_cycles`=0.
- `THRESH`=16; hold `inst_block_sigs`=3'b010, `inst_idle_sigs`=3'b101, `axis_block_sigs`=12'h100 -> `suspect` for 15 cycles, then `block`=1, `cause_axis`=12'h100, `cause_inst`=3'b010, `cause_idx`=8.
- Same stall for 10 cycles, 1 cycle with `stalled`=0, then 10 more cycles -> `block` never asserts, and `stall_cycles` returns to 0 and peaks at 10.
- Stall held but `axis_block_sigs` toggles between 12'h001 and 12'h002 every 8 cycles -> `stall_cycles` restarts at 1 after each change and `block` stays 0.
- After deadlock, change inputs to running; `block` stays 1 with the snapshot unchanged. Pulse `clear` -> next cycle `block`=0 and state RUN.
- Assert `reset` low while `stall_cycles`=12 -> all outputs 0 in the same cycle, without waiting for a clock edge.
